// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared types for the unified-memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_D  = 1'b1
    } arb_src_t;

    localparam logic [2:0]  c_SIZE_WORD = 3'b010;
    localparam int unsigned c_TMR_W     = 8;

endpackage
`default_nettype wire

// File: rtl/riscv_arb_timer.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_arb_timer
//  Description : Clearable up-counter; expired flags the last WAIT cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_arb_timer
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
)(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [c_TMR_W-1:0] c_LAST = c_TMR_W'(TIMEOUT - 1);

    logic [c_TMR_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + c_TMR_W'(1);
        end
    end

    assign expired = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_mem_arbiter
//  Description : Fetch/data arbiter onto one memory port with timeout.
//                Define RISCV_ARB_RR_EN for round-robin arbitration.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [2:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    arb_state_t        r_state, w_state_nxt;
    arb_src_t          r_src, w_win;
    logic              w_grant, w_expired, w_capture, w_timeout;
    logic [DATA_W-1:0] w_cap_data;
    logic              r_err, r_we;
    logic [2:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_if_rdata, r_d_rdata;

    assign w_grant = (r_state == IDLE) && (if_req || d_req);

`ifdef RISCV_ARB_RR_EN
    arb_src_t r_last_src;

    always_comb begin
        if (if_req && d_req) begin
            w_win = (r_last_src == SRC_D) ? SRC_IF : SRC_D;
        end else begin
            w_win = d_req ? SRC_D : SRC_IF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_src <= SRC_IF;
        end else if (w_grant) begin
            r_last_src <= w_win;
        end
    end
`else
    // Data wins so a load stalled in MEM can never be starved by fetch.
    assign w_win = d_req ? SRC_D : SRC_IF;
`endif

    riscv_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (r_state != WAIT),
        .en      (r_state == WAIT),
        .expired (w_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_cap_data  = mem_rdata;
        case (r_state)
            IDLE: if (if_req || d_req) w_state_nxt = REQ;
            REQ: begin
                if (mem_ready) begin
                    if (mem_rvalid) begin
                        w_state_nxt = RESP;
                        w_capture   = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    w_state_nxt = RESP;
                    w_capture   = 1'b1;
                end else if (w_expired) begin
                    w_state_nxt = RESP;
                    w_capture   = 1'b1;
                    w_timeout   = 1'b1;
                    w_cap_data  = '0;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_src      <= SRC_IF;
            r_err      <= 1'b0;
            r_we       <= 1'b0;
            r_size     <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_src   <= w_win;
                r_we    <= (w_win == SRC_D) && d_we;
                r_size  <= (w_win == SRC_D) ? d_size  : c_SIZE_WORD;
                r_addr  <= (w_win == SRC_D) ? d_addr  : if_addr;
                r_wdata <= (w_win == SRC_D) ? d_wdata : '0;
            end
            // Per-source capture keeps each rdata stable between its responses.
            if (w_capture) begin
                if (r_src == SRC_D) begin
                    r_d_rdata <= w_cap_data;
                end else begin
                    r_if_rdata <= w_cap_data;
                end
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (r_state == RESP) begin
                r_err <= 1'b0;
            end
        end
    end

    assign if_gnt    = w_grant && (w_win == SRC_IF);
    assign d_gnt     = w_grant && (w_win == SRC_D);
    assign mem_req   = (r_state == REQ);
    assign mem_we    = r_we;
    assign mem_size  = r_size;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_rvalid = (r_state == RESP) && (r_src == SRC_IF);
    assign d_rvalid  = (r_state == RESP) && (r_src == SRC_D);
    assign err       = (r_state == RESP) && r_err;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_mem_arbiter
//  Description : Random + directed stimulus with a transaction-level scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_mem_arbiter;
    import riscv_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [2:0]  d_size = '0;
    logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, err;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [2:0]  mem_size;

    always #5 clk = ~clk;

    riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err)
    );

    int checks = 0, errors = 0, cyc = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    typedef struct { bit src; logic we; logic [2:0] size; logic [31:0] addr; logic [31:0] wdata; } txn_t;
    typedef struct { bit src; logic [31:0] data; bit err; int due; } resp_t;

    txn_t  txn_q[$];
    resp_t resp_q[$];
    txn_t  m_t;
    resp_t m_r;
    bit    m_busy = 0, m_last = 0, m_src = 0, m_win = 0, after_rst = 0;
    int    m_phase = 0, m_acc = 0;
    logic [1:0] exp_g;
    logic [2:0] exp_rv;

    always @(negedge clk) begin : mon
        cyc++;
        if (rst) begin
            txn_q.delete();
            resp_q.delete();
            m_busy = 0; m_phase = 0; m_last = 0; after_rst = 1;
        end else begin
            if (after_rst) begin
                chk("reset_ctl", {if_gnt, d_gnt, if_rvalid, d_rvalid, err, mem_req, mem_we, mem_size}, '0);
                chk("reset_data", {mem_addr, mem_wdata, if_rdata, d_rdata}, '0);
                after_rst = 0;
            end
            // memory side: request held until accepted, then await data or timeout
            if (m_phase == 1 && txn_q.size() > 0) begin
                m_t = txn_q[0];
                chk("mem_req", mem_req, 1'b1);
                chk("mem_fields", {mem_we, mem_size, mem_addr, (m_t.we ? mem_wdata : 32'h0)},
                                  {m_t.we, m_t.size, m_t.addr, (m_t.we ? m_t.wdata : 32'h0)});
                if (mem_ready) begin
                    m_t = txn_q.pop_front();
                    m_src = m_t.src;
                    if (mem_rvalid) begin
                        resp_q.push_back('{m_src, mem_rdata, 1'b0, cyc + 1});
                        m_phase = 0;
                    end else begin
                        m_phase = 2;
                        m_acc = cyc;
                    end
                end
            end else begin
                chk("mem_req_low", mem_req, 1'b0);
                if (m_phase == 2) begin
                    if (mem_rvalid) begin
                        resp_q.push_back('{m_src, mem_rdata, 1'b0, cyc + 1});
                        m_phase = 0;
                    end else if (cyc - m_acc == TO) begin
                        resp_q.push_back('{m_src, 32'h0, 1'b1, cyc + 1});
                        m_phase = 0;
                    end
                end
            end
            // arbitration: one transaction at a time
            exp_g = 2'b00;
            if (!m_busy && (if_req || d_req)) begin
`ifdef RISCV_ARB_RR_EN
                m_win = (if_req && d_req) ? !m_last : d_req;
`else
                m_win = d_req;
`endif
                exp_g = m_win ? 2'b10 : 2'b01;
            end
            chk("grant", {d_gnt, if_gnt}, exp_g);
            if (exp_g != 2'b00) begin
                if (m_win) txn_q.push_back('{1'b1, d_we, d_size, d_addr, d_wdata});
                else       txn_q.push_back('{1'b0, 1'b0, 3'b010, if_addr, 32'h0});
                m_busy = 1; m_phase = 1; m_last = m_win;
            end
            // response routing
            exp_rv = 3'b000;
            if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
                m_r = resp_q.pop_front();
                exp_rv = {!m_r.src, m_r.src, m_r.err};
                if (m_r.src) chk("d_rdata", d_rdata, m_r.data);
                else         chk("if_rdata", if_rdata, m_r.data);
                m_busy = 0;
            end
            chk("resp", {if_rvalid, d_rvalid, err}, exp_rv);
        end
    end

    // ---------------- stimulus: requesters + memory responder ----------------
    logic [2:0]  sizes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    bit          f_pend = 0, d_pend = 0, tx_open = 0, fix_en = 0;
    int          rv_wait = 0;
    logic [31:0] fix_data = '0;

    task automatic run_cycles(input int n, input int p_new, input int p_ready,
                              input int p_to, input int min_d, input int max_d, input int p_spur);
        int dly;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (!f_pend && $urandom_range(99) < p_new) begin
                f_pend = 1; if_addr = $urandom & 32'hFFFF_FFFC;
            end else if (!f_pend) begin
                if_addr = $urandom;
            end
            if_req = f_pend;
            if (!d_pend && $urandom_range(99) < p_new) begin
                d_pend = 1;
            end
            if (!d_pend || !d_req) begin
                d_we = 1'($urandom_range(1)); d_size = sizes[$urandom_range(4)];
                d_addr = $urandom; d_wdata = $urandom;
            end
            d_req = d_pend;
            mem_ready = 0; mem_rvalid = 0;
            mem_rdata = fix_en ? fix_data : $urandom;
            if (rv_wait > 0) begin
                rv_wait--;
                if (rv_wait == 0) mem_rvalid = 1;
            end else if (mem_req && $urandom_range(99) < p_ready) begin
                mem_ready = 1; tx_open = 1;
                if ($urandom_range(99) >= p_to) begin
                    dly = $urandom_range(max_d, min_d);
                    if (dly == 0) mem_rvalid = 1;
                    else          rv_wait = dly;
                end
            end else if (!mem_req && !tx_open && $urandom_range(99) < p_spur) begin
                mem_rvalid = 1;
            end
            @(negedge clk);
            if (if_gnt) f_pend = 0;
            if (d_gnt)  d_pend = 0;
            if (if_rvalid || d_rvalid) tx_open = 0;
        end
    endtask

    task automatic set_d(input logic we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        d_pend = 1; d_req = 0; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);

        // lone fetch, ready+rvalid together
        f_pend = 1; if_addr = 32'h100; fix_en = 1; fix_data = 32'h0050_0093;
        run_cycles(5, 0, 100, 0, 0, 0, 0);
        fix_en = 0;
        // simultaneous fetch and store
        f_pend = 1; if_addr = 32'h104; set_d(1'b1, 3'b010, 32'h2000, 32'hDEAD_BEEF);
        run_cycles(10, 0, 100, 0, 0, 0, 0);
        // simultaneous again right after a data grant
        set_d(1'b0, 3'b010, 32'h2004, 32'h0);
        run_cycles(4, 0, 100, 0, 0, 0, 0);
        f_pend = 1; if_addr = 32'h108; set_d(1'b0, 3'b100, 32'h2008, 32'h0);
        run_cycles(10, 0, 100, 0, 0, 0, 0);
        // ready back-pressure
        f_pend = 1; if_addr = 32'h10C;
        run_cycles(15, 0, 20, 0, 0, 0, 0);
        // split response, rvalid three cycles after ready
        set_d(1'b0, 3'b010, 32'h3000, 32'h0);
        run_cycles(10, 0, 100, 0, 3, 3, 0);
        // timeout
        f_pend = 1; if_addr = 32'h110;
        run_cycles(12, 0, 100, 100, 0, 0, 0);
        // randomized traffic
        run_cycles(3000, 30, 60, 15, 0, TO, 10);
        run_cycles(40, 0, 100, 0, 0, 0, 0);

        // reset while in WAIT, then a late rvalid
        f_pend = 1; if_addr = 32'h300;
        run_cycles(3, 0, 100, 100, 0, 0, 0);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0; tx_open = 0; rv_wait = 0;
        @(posedge clk); #1 mem_rvalid = 1; mem_rdata = 32'h1234_5678;
        @(posedge clk); #1 mem_rvalid = 0;
        run_cycles(6, 0, 100, 0, 0, 0, 0);
        f_pend = 1; if_addr = 32'h400;
        run_cycles(8, 0, 100, 0, 0, 2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
